// File: rtl/dmem_lsu.sv
// Load/store unit over a word-organised synchronous RAM: one request at a time,
// byte/halfword/word access with sign/zero extension and a registered response.
module dmem_lsu #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] MemData,
    output logic        rsp_err,
    output logic        dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);

    // Handshake: a request transfers on a rising edge with req_valid && req_ready;
    // a response transfers on a rising edge with rsp_valid && rsp_ready. The
    // requester holds its fields until accepted; the response is held until taken.
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        err_q, err_d;
    logic        ld_ok_q, ld_ok_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] rd_word_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] word_idx;
    logic          accept;
    logic          legal;
    logic          misaligned;
    logic          out_of_range;
    logic          req_err;
    logic          do_write;
    logic [3:0]    byte_en;
    logic [31:0]   wdata_lanes;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic [31:0]   load_data;

    assign word_idx  = req_addr[AW+1:2];
    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    always_comb begin
        legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !req_we;
            default:                legal = 1'b0;
        endcase
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = |req_addr[31:AW+2];
        req_err      = !legal || misaligned || out_of_range;
        do_write     = accept && req_we && !req_err;
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        byte_en     = 4'b1111;
        wdata_lanes = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                byte_en     = 4'b0001 << req_addr[1:0];
                wdata_lanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                byte_en     = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{req_wdata[15:0]}};
            end
            default: begin
                byte_en     = 4'b1111;
                wdata_lanes = req_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (do_write && byte_en[i]) begin
                mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
            end
        end
        if (accept) begin
            rd_word_q <= mem[word_idx];
        end
    end

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        err_d       = err_q;
        ld_ok_d     = ld_ok_q;
        funct3_d    = funct3_q;
        lane_d      = lane_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    err_d       = req_err;
                    ld_ok_d     = !req_we && !req_err;
                    funct3_d    = req_funct3;
                    lane_d      = req_addr[1:0];
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    err_d       = 1'b0;
                    ld_ok_d     = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            ld_ok_q     <= 1'b0;
            funct3_q    <= 3'b000;
            lane_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
            ld_ok_q     <= ld_ok_d;
            funct3_q    <= funct3_d;
            lane_q      <= lane_d;
        end
    end

    // Lane extraction works only on latched state, so the output is stable while stalled.
    always_comb begin
        sel_byte = rd_word_q[7:0];
        case (lane_q)
            2'd0: sel_byte = rd_word_q[7:0];
            2'd1: sel_byte = rd_word_q[15:8];
            2'd2: sel_byte = rd_word_q[23:16];
            default: sel_byte = rd_word_q[31:24];
        endcase
        sel_half  = lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
        load_data = 32'h0;
        if (ld_ok_q) begin
            case (funct3_q)
                3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
                3'b100:  load_data = {24'h0, sel_byte};
                3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
                3'b101:  load_data = {16'h0, sel_half};
                3'b010:  load_data = rd_word_q;
                default: load_data = 32'h0;
            endcase
        end
    end

    assign MemData   = load_data;
    assign rsp_err   = err_q;
    assign rsp_valid = rsp_valid_q;
    assign dbg_state = logic'(state_q);

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed load/store/error/backpressure/reset
// scenarios plus a randomized back-to-back run against a byte-lane memory model.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] MemData;
    logic        rsp_err;
    logic        dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [32:0] exp_q[$];
    logic [31:0] model_mem[16];

    dmem_lsu #(.DEPTH_WORDS(256)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .MemData(MemData), .rsp_err(rsp_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Driver: presents a request, waits (bounded) for acceptance, drops valid after
    // the accept edge and samples the response in the following cycle.
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic ov, output logic oe,
                        output logic [31:0] od);
        int cyc;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        cyc = 0;
        while (req_ready !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (req_ready === 1'b1) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            @(negedge clk);
            ov = rsp_valid; oe = rsp_err; od = MemData;
        end else begin
            req_valid = 1'b0;
            ov = 1'b0; oe = 1'bx; od = 'x;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_low: req_ready=%b expected 0", req_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || MemData !== 32'h0 ||
            rsp_err !== 1'b0 || dbg_state !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: ready=%b valid=%b data=%08h err=%b st=%b expected 1 0 00000000 0 0",
                     req_ready, rsp_valid, MemData, rsp_err, dbg_state);
        end
    endtask

    task automatic test_loads;
        logic ov, oe;
        logic [31:0] od;
        logic [32:0] e;
        logic [2:0]  f3_t[5]   = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] addr_t[5] = '{32'h10, 32'h10, 32'h13, 32'h12, 32'h12};
        logic [31:0] exp_t[5]  = '{32'h8000_00F1, 32'hFFFF_FFF1, 32'h0000_0080,
                                   32'hFFFF_8000, 32'h0000_8000};
        exp_q.push_back({1'b0, 32'h0});
        send(1'b1, 3'b010, 32'h10, 32'h8000_00F1, ov, oe, od);
        e = exp_q.pop_front();
        n_tests++;
        if (ov !== 1'b1 || {oe, od} !== e) begin
            n_fail++;
            $display("FAIL sw_0x10: valid=%b err=%b data=%08h expected valid=1 err=%b data=%08h",
                     ov, oe, od, e[32], e[31:0]);
        end
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({1'b0, exp_t[i]});
            send(1'b0, f3_t[i], addr_t[i], 32'h0, ov, oe, od);
            e = exp_q.pop_front();
            n_tests++;
            if (ov !== 1'b1 || {oe, od} !== e) begin
                n_fail++;
                $display("FAIL load_%0d: valid=%b err=%b data=%08h expected valid=1 err=%b data=%08h",
                         i, ov, oe, od, e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_partial_stores;
        logic ov, oe;
        logic [31:0] od;
        logic [32:0] e;
        logic [2:0]  f3_t[4]   = '{3'b010, 3'b000, 3'b001, 3'b010};
        logic        we_t[4]   = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] addr_t[4] = '{32'h20, 32'h21, 32'h22, 32'h20};
        logic [31:0] wd_t[4]   = '{32'h1122_3344, 32'h0000_00AA, 32'h0000_BEEF, 32'h0};
        logic [31:0] exp_t[4]  = '{32'h0, 32'h0, 32'h0, 32'hBEEF_AA44};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b0, exp_t[i]});
            send(we_t[i], f3_t[i], addr_t[i], wd_t[i], ov, oe, od);
            e = exp_q.pop_front();
            n_tests++;
            if (ov !== 1'b1 || {oe, od} !== e) begin
                n_fail++;
                $display("FAIL partial_%0d: valid=%b err=%b data=%08h expected valid=1 err=%b data=%08h",
                         i, ov, oe, od, e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_errors;
        logic ov, oe;
        logic [31:0] od;
        logic [32:0] e;
        logic [2:0]  f3_t[7]   = '{3'b010, 3'b001, 3'b010, 3'b010, 3'b100, 3'b010, 3'b011};
        logic        we_t[7]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] addr_t[7] = '{32'h22, 32'h21, 32'h20, 32'h400, 32'h20, 32'h20, 32'h20};
        logic [31:0] wd_t[7]   = '{32'h0, 32'h0000_5566, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
        logic [32:0] exp_t[7]  = '{{1'b1, 32'h0}, {1'b1, 32'h0}, {1'b0, 32'hBEEF_AA44},
                                   {1'b1, 32'h0}, {1'b1, 32'h0}, {1'b0, 32'hBEEF_AA44},
                                   {1'b1, 32'h0}};
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(exp_t[i]);
            send(we_t[i], f3_t[i], addr_t[i], wd_t[i], ov, oe, od);
            e = exp_q.pop_front();
            n_tests++;
            if (ov !== 1'b1 || {oe, od} !== e) begin
                n_fail++;
                $display("FAIL error_%0d: valid=%b err=%b data=%08h expected valid=1 err=%b data=%08h",
                         i, ov, oe, od, e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic ov, oe;
        logic [31:0] od;
        logic [32:0] e;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = '0;
        exp_q.push_back({1'b0, 32'h8000_00F1});
        @(posedge clk);
        #1;
        // A second request is presented immediately and must be held off.
        req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFE_0001;
        e = exp_q.pop_front();
        exp_q.push_back({1'b0, 32'h0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (rsp_valid !== 1'b1 || {rsp_err, MemData} !== e || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_%0d: valid=%b err=%b data=%08h ready=%b expected 1 %b %08h 0",
                         i, rsp_valid, rsp_err, MemData, req_ready, e[32], e[31:0]);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: valid=%b ready=%b expected 0 1", rsp_valid, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if (rsp_valid !== 1'b1 || {rsp_err, MemData} !== e) begin
            n_fail++;
            $display("FAIL held_store: valid=%b err=%b data=%08h expected 1 %b %08h",
                     rsp_valid, rsp_err, MemData, e[32], e[31:0]);
        end
        exp_q.push_back({1'b0, 32'hCAFE_0001});
        send(1'b0, 3'b010, 32'h40, 32'h0, ov, oe, od);
        e = exp_q.pop_front();
        n_tests++;
        if (ov !== 1'b1 || {oe, od} !== e) begin
            n_fail++;
            $display("FAIL held_store_readback: valid=%b err=%b data=%08h expected 1 %b %08h",
                     ov, oe, od, e[32], e[31:0]);
        end
    endtask

    task automatic test_reset_mid_resp;
        logic ov, oe;
        logic [31:0] od;
        logic [32:0] e;
        exp_q.push_back({1'b0, 32'h0});
        send(1'b1, 3'b010, 32'h30, 32'h0000_1234, ov, oe, od);
        e = exp_q.pop_front();
        n_tests++;
        if (ov !== 1'b1 || {oe, od} !== e) begin
            n_fail++;
            $display("FAIL sw_0x30: valid=%b err=%b data=%08h expected 1 %b %08h", ov, oe, od, e[32], e[31:0]);
        end
        exp_q.push_back({1'b0, 32'h0});
        send(1'b1, 3'b010, 32'h50, 32'h1111_1111, ov, oe, od);
        e = exp_q.pop_front();
        n_tests++;
        if (ov !== 1'b1 || {oe, od} !== e) begin
            n_fail++;
            $display("FAIL sw_0x50: valid=%b err=%b data=%08h expected 1 %b %08h", ov, oe, od, e[32], e[31:0]);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h30;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b1 || MemData !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL pre_reset_rsp: valid=%b data=%08h expected 1 00001234", rsp_valid, MemData);
        end
        // Reset while a store is being offered: it must not be accepted or written.
        reset = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h50; req_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b0 || dbg_state !== 1'b0 || MemData !== 32'h0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_resp: valid=%b st=%b data=%08h ready=%b expected 0 0 00000000 0",
                     rsp_valid, dbg_state, MemData, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        rsp_ready = 1'b1;
        exp_q.push_back({1'b0, 32'h0000_1234});
        send(1'b0, 3'b010, 32'h30, 32'h0, ov, oe, od);
        e = exp_q.pop_front();
        n_tests++;
        if (ov !== 1'b1 || {oe, od} !== e) begin
            n_fail++;
            $display("FAIL post_reset_0x30: valid=%b err=%b data=%08h expected 1 %b %08h", ov, oe, od, e[32], e[31:0]);
        end
        exp_q.push_back({1'b0, 32'h1111_1111});
        send(1'b0, 3'b010, 32'h50, 32'h0, ov, oe, od);
        e = exp_q.pop_front();
        n_tests++;
        if (ov !== 1'b1 || {oe, od} !== e) begin
            n_fail++;
            $display("FAIL reset_blocks_store: valid=%b err=%b data=%08h expected 1 %b %08h", ov, oe, od, e[32], e[31:0]);
        end
    endtask

    task automatic test_back_to_back;
        logic ov, oe;
        logic [31:0] od, w, addr, wd, res;
        logic [32:0] e;
        logic [7:0]  b;
        logic [15:0] h;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic        we, err;
        int          wi, op;
        logic [2:0]  ld_f3[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = $urandom;
            exp_q.push_back({1'b0, 32'h0});
            send(1'b1, 3'b010, 32'h100 + 32'(4*i), model_mem[i], ov, oe, od);
            e = exp_q.pop_front();
            n_tests++;
            if (ov !== 1'b1 || {oe, od} !== e) begin
                n_fail++;
                $display("FAIL b2b_init_%0d: valid=%b err=%b data=%08h expected 1 %b %08h", i, ov, oe, od, e[32], e[31:0]);
            end
        end
        for (int n = 0; n < 80; n++) begin
            wi = $urandom_range(0, 15);
            lo = 2'($urandom_range(0, 3));
            op = $urandom_range(0, 5);
            we = (op < 3);
            f3 = we ? 3'(op) : ld_f3[$urandom_range(0, 4)];
            addr = 32'h100 + 32'(4*wi) + 32'(lo);
            wd = $urandom;
            err = ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
            w = model_mem[wi];
            b = w[8*lo +: 8];
            h = lo[1] ? w[31:16] : w[15:0];
            res = 32'h0;
            if (!err && we) begin
                case (f3)
                    3'b000:  w[8*lo +: 8] = wd[7:0];
                    3'b001:  w[16*lo[1] +: 16] = wd[15:0];
                    default: w = wd;
                endcase
                model_mem[wi] = w;
            end else if (!err) begin
                case (f3)
                    3'b000:  res = {{24{b[7]}}, b};
                    3'b100:  res = {24'h0, b};
                    3'b001:  res = {{16{h[15]}}, h};
                    3'b101:  res = {16'h0, h};
                    default: res = w;
                endcase
            end
            exp_q.push_back({err, res});
            send(we, f3, addr, wd, ov, oe, od);
            e = exp_q.pop_front();
            n_tests++;
            if (ov !== 1'b1 || {oe, od} !== e) begin
                n_fail++;
                $display("FAIL b2b_%0d we=%b f3=%0d addr=%08h: valid=%b err=%b data=%08h expected 1 %b %08h",
                         n, we, f3, addr, ov, oe, od, e[32], e[31:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_partial_stores();
        test_errors();
        test_backpressure();
        test_reset_mid_resp();
        test_back_to_back();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
